// File: rtl/udp_lb_traffic_gen_chk_if.sv
// AXI-Stream bundle for the loopback generator/checker. The master drives the
// beat, the slave returns tready.
interface udp_lb_traffic_gen_chk_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tlast;
    logic                tready;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/udp_lb_traffic_gen_chk.sv
// Loopback traffic generator (sequence-numbered frames with a counting byte
// pattern) and a free-running checker counting packet, data and sequence errors.
module udp_lb_traffic_gen_chk #(
    parameter int DATA_W = 64,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 32
) (
    input  logic                sys_clk,
    input  logic                sys_reset_n,
    input  logic                start,
    input  logic                stop,
    input  logic [LEN_W-1:0]    pkt_len,
    input  logic [CNT_W-1:0]    pkt_num,
    input  logic [7:0]          ipg,
    udp_lb_traffic_gen_chk_if.master tx,
    udp_lb_traffic_gen_chk_if.slave  rx,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    tx_pkt_cnt,
    output logic [CNT_W-1:0]    rx_pkt_cnt,
    output logic [CNT_W-1:0]    rx_err_cnt,
    output logic [CNT_W-1:0]    rx_seq_err_cnt
);
    localparam int B     = DATA_W / 8;
    localparam int OFF_W = LEN_W + 1;
    localparam logic [OFF_W-1:0] B_OFF = OFF_W'(B);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} gen_state_e;
    typedef enum logic       {RX_HDR, RX_BODY}        rx_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [7:0] pat_byte(input logic [7:0] seq_lo,
                                            input logic [OFF_W-1:0] off, input int j);
        return seq_lo + off[7:0] + 8'(j);
    endfunction

    gen_state_e         gen_state, gen_next;
    rx_state_e          rx_state, rx_next;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   num_q;
    logic [7:0]         ipg_q, gap_cnt;
    logic [OFF_W-1:0]   tx_off, tx_rem;
    logic [31:0]        tx_seq;
    logic               start_ok, tx_fire, tx_last_beat, frame_end;
    logic [CNT_W-1:0]   tx_cnt_inc;

    logic [OFF_W-1:0]   rx_off, rx_rem;
    logic [31:0]        rx_seq_q, exp_seq, cur_seq;
    logic               rx_hdr, rx_exp_last, beat_err, frame_err;

    // ------------------------------------------------------------------ generator
    assign start_ok     = start && (gen_state == IDLE || gen_state == DONE);
    assign tx_rem       = {1'b0, len_q} - tx_off;
    assign tx_last_beat = tx_rem <= B_OFF;
    assign tx_fire      = tx.tvalid && tx.tready;
    assign frame_end    = tx_fire && tx_last_beat;
    assign tx_cnt_inc   = sat_inc(tx_pkt_cnt);
    assign busy         = (gen_state == SEND) || (gen_state == GAP);
    assign done         = (gen_state == DONE);

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) gen_state <= IDLE;
        else              gen_state <= gen_next;
    end

    // NOTE: every combinational output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        gen_next = gen_state;
        unique case (gen_state)
            IDLE, DONE: if (start) gen_next = SEND;
            SEND: if (frame_end) begin
                if (num_q != '0 && tx_cnt_inc == num_q) gen_next = DONE;
                else if (stop)                          gen_next = DONE;
                else if (ipg_q == 8'd0)                 gen_next = SEND;
                else                                    gen_next = GAP;
            end
            GAP: begin
                if (stop)                 gen_next = DONE;
                else if (gap_cnt == 8'd1) gen_next = SEND;
            end
            default: gen_next = IDLE;
        endcase
    end

    // NOTE: all state is written with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            len_q      <= LEN_W'(8);
            num_q      <= '0;
            ipg_q      <= '0;
            gap_cnt    <= '0;
            tx_off     <= '0;
            tx_seq     <= '0;
            tx_pkt_cnt <= '0;
        end else begin
            if (start_ok) begin
                len_q      <= (pkt_len < LEN_W'(8)) ? LEN_W'(8) : pkt_len;
                num_q      <= pkt_num;
                ipg_q      <= ipg;
                tx_off     <= '0;
                tx_seq     <= '0;
                tx_pkt_cnt <= '0;
            end else if (tx_fire) begin
                if (tx_last_beat) begin
                    tx_off     <= '0;
                    tx_seq     <= tx_seq + 32'd1;
                    tx_pkt_cnt <= tx_cnt_inc;
                end else begin
                    tx_off <= tx_off + B_OFF;
                end
            end
            // Preloaded during SEND so GAP lasts exactly ipg_q cycles.
            if (gen_state == GAP) gap_cnt <= gap_cnt - 8'd1;
            else                  gap_cnt <= ipg_q;
        end
    end

    // Beat contents derive only from registered state, so they hold under stall.
    always_comb begin
        tx.tvalid = 1'b0;
        tx.tlast  = 1'b0;
        tx.tkeep  = '0;
        tx.tdata  = '0;
        if (gen_state == SEND) begin
            tx.tvalid = 1'b1;
            tx.tlast  = tx_last_beat;
            for (int j = 0; j < B; j++) begin
                tx.tkeep[j]        = !tx_last_beat || (OFF_W'(j) < tx_rem);
                tx.tdata[8*j +: 8] = pat_byte(tx_seq[7:0], tx_off, j);
            end
            if (tx_off == '0) tx.tdata[31:0] = tx_seq;
        end
    end

    // -------------------------------------------------------------------- checker
    assign rx.tready   = 1'b1;
    assign rx_hdr      = (rx_state == RX_HDR);
    assign cur_seq     = rx_hdr ? rx.tdata[31:0] : rx_seq_q;
    assign rx_rem      = {1'b0, len_q} - rx_off;
    assign rx_exp_last = rx_rem <= B_OFF;

    always_comb begin
        beat_err = (rx.tlast != rx_exp_last);
        for (int j = 0; j < B; j++) begin
            if (rx.tkeep[j] != (!rx_exp_last || (OFF_W'(j) < rx_rem))) beat_err = 1'b1;
            if (rx.tkeep[j] && (!rx_hdr || j >= 4) &&
                rx.tdata[8*j +: 8] != pat_byte(cur_seq[7:0], rx_off, j)) beat_err = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) rx_state <= RX_HDR;
        else              rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        if (rx.tvalid) rx_next = rx.tlast ? RX_HDR : RX_BODY;
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            rx_off    <= '0;
            rx_seq_q  <= '0;
            frame_err <= 1'b0;
        end else if (rx.tvalid) begin
            if (rx_hdr) rx_seq_q <= rx.tdata[31:0];
            if (rx.tlast) begin
                rx_off    <= '0;
                frame_err <= 1'b0;
            end else begin
                rx_off    <= rx_off + B_OFF;
                frame_err <= frame_err | beat_err;
            end
        end
    end

    // A start clears the statistics even if a frame is arriving in that cycle.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            exp_seq        <= '0;
            rx_pkt_cnt     <= '0;
            rx_err_cnt     <= '0;
            rx_seq_err_cnt <= '0;
        end else if (start_ok) begin
            exp_seq        <= '0;
            rx_pkt_cnt     <= '0;
            rx_err_cnt     <= '0;
            rx_seq_err_cnt <= '0;
        end else if (rx.tvalid) begin
            if (rx_hdr && rx.tdata[31:0] != exp_seq) rx_seq_err_cnt <= sat_inc(rx_seq_err_cnt);
            if (rx.tlast) begin
                exp_seq    <= cur_seq + 32'd1;
                rx_pkt_cnt <= sat_inc(rx_pkt_cnt);
                if (frame_err || beat_err) rx_err_cnt <= sat_inc(rx_err_cnt);
            end
        end
    end
endmodule

// File: tb/tb_udp_lb_traffic_gen_chk.sv
// Directed bench: TX is looped to RX (optionally corrupted or dropped) and an
// independent monitor models the frame format, gaps and stall stability.
module tb_udp_lb_traffic_gen_chk;
    logic        sys_clk = 1'b0;
    logic        sys_reset_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0;
    logic [15:0] pkt_len = '0;
    logic [31:0] pkt_num = '0;
    logic [7:0]  ipg = '0;
    logic        busy, done;
    logic [31:0] tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt, rx_seq_err_cnt;

    int checks = 0, errors = 0;
    int tb_len = 8;
    bit mon_clr = 1'b1, corrupt_en = 1'b0, drop_en = 1'b0;

    udp_lb_traffic_gen_chk_if #(.DATA_W(64)) tx_if ();
    udp_lb_traffic_gen_chk_if #(.DATA_W(64)) rx_if ();

    udp_lb_traffic_gen_chk #(.DATA_W(64), .LEN_W(16), .CNT_W(32)) dut (
        .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .start(start), .stop(stop),
        .pkt_len(pkt_len), .pkt_num(pkt_num), .ipg(ipg), .tx(tx_if), .rx(rx_if),
        .busy(busy), .done(done), .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt),
        .rx_err_cnt(rx_err_cnt), .rx_seq_err_cnt(rx_seq_err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------------------------------------------------------- monitor state
    int          cyc, mon_frames, mon_beat, beats_total, first_cyc, last_tlast_cyc, done_rise_cyc;
    int          stall_viol, pat_err, keep_err, gap_cnt, gap_min, gap_max, n_gaps;
    bit          seen_first, in_gap, prev_valid, prev_ready, prev_last, prev_done;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;
    int          frame_beats[64];
    logic [7:0]  frame_keep[64];
    wire         hs = tx_if.tvalid && tx_if.tready;

    // Loopback path: rx sees every accepted tx beat, with optional faults.
    assign rx_if.tvalid = hs && !(drop_en && mon_frames == 1);
    assign rx_if.tdata  = tx_if.tdata ^ ((corrupt_en && mon_frames == 2 && mon_beat == 1) ?
                                         64'h0000_0000_00FF_0000 : 64'h0);
    assign rx_if.tkeep  = tx_if.tkeep;
    assign rx_if.tlast  = tx_if.tlast;

    function automatic logic [7:0] exp_keep_f(int len, int beat);
        int rem = len - beat * 8;
        if (rem >= 8) return 8'hFF;
        if (rem <= 0) return 8'h00;
        return 8'((1 << rem) - 1);
    endfunction

    function automatic bit beat_bad(logic [63:0] d, int seq, int len, int beat);
        logic [7:0]  keep;
        logic [31:0] s;
        logic [7:0]  e;
        int          k;
        keep = exp_keep_f(len, beat);
        s    = 32'(seq);
        for (int j = 0; j < 8; j++) begin
            if (keep[j]) begin
                k = beat * 8 + j;
                e = (k < 4) ? s[8*k +: 8] : 8'(s[7:0] + k);
                if (d[8*j +: 8] !== e) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    always @(posedge sys_clk) begin
        prev_valid <= tx_if.tvalid;
        prev_ready <= tx_if.tready;
        prev_data  <= tx_if.tdata;
        prev_keep  <= tx_if.tkeep;
        prev_last  <= tx_if.tlast;
        prev_done  <= done;
        if (mon_clr) begin
            cyc <= 0; mon_frames <= 0; mon_beat <= 0; beats_total <= 0;
            first_cyc <= -1; last_tlast_cyc <= -1; done_rise_cyc <= -1;
            stall_viol <= 0; pat_err <= 0; keep_err <= 0;
            gap_cnt <= 0; gap_min <= 255; gap_max <= 0; n_gaps <= 0;
            seen_first <= 1'b0; in_gap <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (prev_valid && !prev_ready &&
                (!tx_if.tvalid || tx_if.tdata !== prev_data ||
                 tx_if.tkeep !== prev_keep || tx_if.tlast !== prev_last))
                stall_viol <= stall_viol + 1;
            if (done && !prev_done) done_rise_cyc <= cyc;
            if (in_gap) begin
                if (tx_if.tvalid) begin
                    in_gap <= 1'b0;
                    n_gaps <= n_gaps + 1;
                    if (gap_cnt < gap_min) gap_min <= gap_cnt;
                    if (gap_cnt > gap_max) gap_max <= gap_cnt;
                end else begin
                    gap_cnt <= gap_cnt + 1;
                end
            end
            if (hs) begin
                if (!seen_first) begin
                    seen_first <= 1'b1;
                    first_cyc  <= cyc;
                end
                beats_total <= beats_total + 1;
                if (beat_bad(tx_if.tdata, mon_frames, tb_len, mon_beat)) pat_err <= pat_err + 1;
                if (tx_if.tkeep !== exp_keep_f(tb_len, mon_beat) ||
                    tx_if.tlast !== (tb_len - mon_beat * 8 <= 8)) keep_err <= keep_err + 1;
                if (tx_if.tlast) begin
                    frame_beats[mon_frames % 64] <= mon_beat + 1;
                    frame_keep[mon_frames % 64]  <= tx_if.tkeep;
                    mon_frames     <= mon_frames + 1;
                    mon_beat       <= 0;
                    last_tlast_cyc <= cyc;
                    in_gap         <= 1'b1;
                    gap_cnt        <= 0;
                end else begin
                    mon_beat <= mon_beat + 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------ helpers
    task automatic start_run(input int len, input int num, input int gap);
        @(negedge sys_clk);
        pkt_len = 16'(len); pkt_num = 32'(num); ipg = 8'(gap);
        tb_len  = (len < 8) ? 8 : len;
        mon_clr = 1'b1; start = 1'b1;
        @(negedge sys_clk);
        mon_clr = 1'b0; start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rand_ready);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge sys_clk);
            if (rand_ready) tx_if.tready = 1'($urandom_range(0, 1));
            n++;
        end
        tx_if.tready = 1'b1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: done=%0b required 1 within %0d cycles", done, budget);
        end
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic check_counts(input string tag, input int etx, input int erx,
                                input int eerr, input int eseq);
        checks += 4;
        if (tx_pkt_cnt !== 32'(etx)) begin errors++; $display("FAIL %s tx_pkt_cnt: got %0d expected %0d", tag, tx_pkt_cnt, etx); end
        if (rx_pkt_cnt !== 32'(erx)) begin errors++; $display("FAIL %s rx_pkt_cnt: got %0d expected %0d", tag, rx_pkt_cnt, erx); end
        if (rx_err_cnt !== 32'(eerr)) begin errors++; $display("FAIL %s rx_err_cnt: got %0d expected %0d", tag, rx_err_cnt, eerr); end
        if (rx_seq_err_cnt !== 32'(eseq)) begin errors++; $display("FAIL %s rx_seq_err_cnt: got %0d expected %0d", tag, rx_seq_err_cnt, eseq); end
    endtask

    task automatic check_format(input string tag);
        checks += 2;
        if (pat_err !== 0) begin errors++; $display("FAIL %s pattern: got %0d bad beats expected 0", tag, pat_err); end
        if (keep_err !== 0) begin errors++; $display("FAIL %s tkeep/tlast: got %0d bad beats expected 0", tag, keep_err); end
    endtask

    // -------------------------------------------------------------------- tests
    task automatic test_reset();
        tx_if.tready = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks += 3;
        if (tx_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset tvalid: got %0b expected 0", tx_if.tvalid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %0b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %0b expected 0", done); end
        check_counts("reset", 0, 0, 0, 0);
        sys_reset_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        checks++;
        if (tx_if.tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle after reset: tvalid=%0b busy=%0b expected 0/0", tx_if.tvalid, busy);
        end
    endtask

    task automatic test_back_to_back();
        start_run(64, 4, 0);
        checks++;
        if (tx_if.tvalid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b first beat: tvalid=%0b busy=%0b expected 1/1", tx_if.tvalid, busy);
        end
        wait_done(200, 1'b0);
        check_counts("b2b", 4, 4, 0, 0);
        check_format("b2b");
        checks += 4;
        if (beats_total !== 32) begin errors++; $display("FAIL b2b beats: got %0d expected 32", beats_total); end
        if (last_tlast_cyc - first_cyc !== 31) begin errors++; $display("FAIL b2b contiguous span: got %0d expected 31", last_tlast_cyc - first_cyc); end
        if (done_rise_cyc - last_tlast_cyc !== 1) begin errors++; $display("FAIL b2b done latency: got %0d expected 1", done_rise_cyc - last_tlast_cyc); end
        if (n_gaps !== 3 || gap_max !== 0) begin errors++; $display("FAIL b2b gaps: got n=%0d max=%0d expected n=3 max=0", n_gaps, gap_max); end
    endtask

    task automatic test_lengths();
        start_run(61, 2, 0);
        wait_done(200, 1'b0);
        check_counts("len61", 2, 2, 0, 0);
        check_format("len61");
        checks += 2;
        if (frame_beats[1] !== 8) begin errors++; $display("FAIL len61 beats: got %0d expected 8", frame_beats[1]); end
        if (frame_keep[1] !== 8'h1F) begin errors++; $display("FAIL len61 last tkeep: got %h expected 1f", frame_keep[1]); end
        start_run(3, 2, 0);
        wait_done(200, 1'b0);
        check_counts("len3", 2, 2, 0, 0);
        check_format("len3");
        checks += 2;
        if (frame_beats[0] !== 1) begin errors++; $display("FAIL len3 beats: got %0d expected 1", frame_beats[0]); end
        if (frame_keep[0] !== 8'hFF) begin errors++; $display("FAIL len3 tkeep: got %h expected ff", frame_keep[0]); end
    endtask

    task automatic test_stall_ipg();
        start_run(64, 20, 5);
        wait_done(5000, 1'b1);
        check_counts("stall", 20, 20, 0, 0);
        check_format("stall");
        checks += 2;
        if (stall_viol !== 0) begin errors++; $display("FAIL stall stability: got %0d violations expected 0", stall_viol); end
        if (n_gaps !== 19 || gap_min !== 5 || gap_max !== 5) begin
            errors++; $display("FAIL ipg: got n=%0d min=%0d max=%0d expected 19/5/5", n_gaps, gap_min, gap_max);
        end
    endtask

    task automatic test_corrupt();
        corrupt_en = 1'b1;
        start_run(64, 4, 2);
        wait_done(500, 1'b0);
        corrupt_en = 1'b0;
        check_counts("corrupt", 4, 4, 1, 0);
    endtask

    task automatic test_drop();
        drop_en = 1'b1;
        start_run(64, 4, 0);
        wait_done(500, 1'b0);
        drop_en = 1'b0;
        check_counts("drop", 4, 3, 0, 1);
    endtask

    task automatic test_stop_reset();
        int n = 0;
        start_run(64, 0, 0);
        while (!(mon_frames == 1 && mon_beat == 3 && tx_if.tvalid) && n < 200) begin
            @(negedge sys_clk); n++;
        end
        stop = 1'b1;
        wait_done(200, 1'b0);
        stop = 1'b0;
        check_counts("stop", 2, 2, 0, 0);
        checks++;
        if (frame_beats[1] !== 8) begin errors++; $display("FAIL stop last frame beats: got %0d expected 8", frame_beats[1]); end

        start_run(64, 0, 0);
        n = 0;
        while (!(mon_frames == 2 && mon_beat == 4 && tx_if.tvalid) && n < 200) begin
            @(negedge sys_clk); n++;
        end
        checks++;
        if (tx_pkt_cnt !== 32'd2) begin errors++; $display("FAIL pre-reset tx_pkt_cnt: got %0d expected 2", tx_pkt_cnt); end
        sys_reset_n = 1'b0;
        #1;
        checks += 2;
        if (tx_if.tvalid !== 1'b0 || tx_if.tlast !== 1'b0) begin
            errors++; $display("FAIL mid-frame reset: tvalid=%0b tlast=%0b expected 0/0", tx_if.tvalid, tx_if.tlast);
        end
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid-frame reset: busy=%0b done=%0b expected 0/0", busy, done);
        end
        check_counts("reset_mid", 0, 0, 0, 0);
        @(negedge sys_clk);
        sys_reset_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_lengths();
        test_stall_ipg();
        test_corrupt();
        test_drop();
        test_stop_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
